// File: rtl/init_reset_sequencer.sv
// -----------------------------------------------------------------------------
// init_reset_sequencer
//
// Power-up / recovery reset sequencer. Waits until the device-init and PLL-lock
// qualifiers have been high together for FILTER_CYCLES consecutive cycles, then
// releases NUM_CH active-low resets one at a time, STAGGER_CYCLES apart. A
// software request re-pulses all resets for HOLD_CYCLES and re-runs the
// staggered release without repeating the filter. Losing either qualifier after
// the filter has passed drops every reset and restarts from WAIT. Staying in
// WAIT for TIMEOUT_CYCLES latches a fault that only RESET clears.
//
// Ports
//   CLK              in   fabric clock, rising edge
//   RESET            in   synchronous active-high reset
//   DEVICE_INIT_DONE in   device-init-complete qualifier
//   PLL_LOCK         in   PLL lock qualifier
//   SW_RESET_REQ     in   single-cycle software reset request (honoured in RUN)
//   RESET_N_OUT      out  [NUM_CH-1:0] active-low channel resets, bit k freed k-th
//   ALL_RELEASED     out  high while in RUN
//   FAULT            out  sticky timeout flag
//   LED              out  status: off WAIT/HOLD, on RELEASE/RUN, blinks in FAULT
//   STATE            out  [2:0] WAIT=0 RELEASE=1 RUN=2 HOLD=3 FAULT=4
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module init_reset_sequencer #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned FILTER_CYCLES  = 16,
  parameter int unsigned STAGGER_CYCLES = 8,
  parameter int unsigned HOLD_CYCLES    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned BLINK_DIV      = 25000000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              DEVICE_INIT_DONE,
  input  logic              PLL_LOCK,
  input  logic              SW_RESET_REQ,
  output logic [NUM_CH-1:0] RESET_N_OUT,
  output logic              ALL_RELEASED,
  output logic              FAULT,
  output logic              LED,
  output logic [2:0]        STATE
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [15:0] FILTER_MAX  = 16'(FILTER_CYCLES);
  localparam logic [15:0] STAGGER_TC  = 16'(STAGGER_CYCLES - 1);
  localparam logic [15:0] HOLD_TC     = 16'(HOLD_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_MAX = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] BLINK_TC    = 32'(BLINK_DIV - 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_WAIT    = 3'd0,
    S_RELEASE = 3'd1,
    S_RUN     = 3'd2,
    S_HOLD    = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [15:0]       filter_reg, filter_next;
  logic [31:0]       timeout_reg, timeout_next;
  logic [15:0]       stagger_reg, stagger_next;
  logic [CH_W-1:0]   ch_idx_reg, ch_idx_next;
  logic [15:0]       hold_reg, hold_next;
  logic [31:0]       blink_reg, blink_next;
  logic [NUM_CH-1:0] rst_n_reg, rst_n_next;
  logic              all_rel_reg, all_rel_next;
  logic              fault_reg, fault_next;
  logic              led_reg, led_next;

  logic              qual_ok;
  logic              stagger_tc;
  logic [NUM_CH-1:0] chan_set;

  assign qual_ok    = DEVICE_INIT_DONE & PLL_LOCK;
  assign stagger_tc = (stagger_reg == STAGGER_TC);

  // One-hot strobe for the channel whose stagger slot ends this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan_set
      assign chan_set[gi] = (state_reg == S_RELEASE) && stagger_tc &&
                            (ch_idx_reg == CH_W'(gi));
    end
  endgenerate

  // Defaults describe WAIT with everything cleared; each state overrides only
  // what it keeps. Qualifier loss is tested before any other event in the
  // post-filter states so it always wins.
  always_comb begin
    state_next   = state_reg;
    filter_next  = '0;
    timeout_next = '0;
    stagger_next = '0;
    ch_idx_next  = '0;
    hold_next    = '0;
    blink_next   = '0;
    rst_n_next   = '0;
    all_rel_next = 1'b0;
    fault_next   = 1'b0;
    led_next     = 1'b0;

    case (state_reg)
      S_WAIT: begin
        if (timeout_reg != 32'hFFFF_FFFF) timeout_next = timeout_reg + 32'd1;
        else                               timeout_next = timeout_reg;
        if (qual_ok) begin
          if (filter_reg != FILTER_MAX) filter_next = filter_reg + 16'd1;
          else                          filter_next = filter_reg;
        end
        if (qual_ok && (filter_reg == FILTER_MAX)) begin
          state_next   = S_RELEASE;
          filter_next  = '0;
          timeout_next = '0;
          led_next     = 1'b1;
        end else if (timeout_reg == TIMEOUT_MAX) begin
          state_next   = S_FAULT;
          filter_next  = '0;
          timeout_next = '0;
          fault_next   = 1'b1;
          led_next     = 1'b1;
        end
      end

      S_RELEASE: begin
        if (!qual_ok) begin
          state_next = S_WAIT;
        end else begin
          led_next   = 1'b1;
          rst_n_next = rst_n_reg | chan_set;
          if (stagger_tc) begin
            stagger_next = '0;
            if (ch_idx_reg == LAST_CH) begin
              state_next   = S_RUN;
              all_rel_next = 1'b1;
            end else begin
              ch_idx_next = ch_idx_reg + CH_W'(1);
            end
          end else begin
            stagger_next = stagger_reg + 16'd1;
            ch_idx_next  = ch_idx_reg;
          end
        end
      end

      S_RUN: begin
        if (!qual_ok) begin
          state_next = S_WAIT;
        end else if (SW_RESET_REQ) begin
          state_next = S_HOLD;
        end else begin
          rst_n_next   = '1;
          all_rel_next = 1'b1;
          led_next     = 1'b1;
        end
      end

      S_HOLD: begin
        if (!qual_ok) begin
          state_next = S_WAIT;
        end else if (hold_reg == HOLD_TC) begin
          // Filter already proven; go straight to the staggered release.
          state_next = S_RELEASE;
          led_next   = 1'b1;
        end else begin
          hold_next = hold_reg + 16'd1;
        end
      end

      S_FAULT: begin
        fault_next = 1'b1;
        if (blink_reg == BLINK_TC) begin
          blink_next = '0;
          led_next   = ~led_reg;
        end else begin
          blink_next = blink_reg + 32'd1;
          led_next   = led_reg;
        end
      end

      default: begin
        state_next = S_WAIT;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= S_WAIT;
      filter_reg  <= '0;
      timeout_reg <= '0;
      stagger_reg <= '0;
      ch_idx_reg  <= '0;
      hold_reg    <= '0;
      blink_reg   <= '0;
      rst_n_reg   <= '0;
      all_rel_reg <= 1'b0;
      fault_reg   <= 1'b0;
      led_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      filter_reg  <= filter_next;
      timeout_reg <= timeout_next;
      stagger_reg <= stagger_next;
      ch_idx_reg  <= ch_idx_next;
      hold_reg    <= hold_next;
      blink_reg   <= blink_next;
      rst_n_reg   <= rst_n_next;
      all_rel_reg <= all_rel_next;
      fault_reg   <= fault_next;
      led_reg     <= led_next;
    end
  end

  assign RESET_N_OUT  = rst_n_reg;
  assign ALL_RELEASED = all_rel_reg;
  assign FAULT        = fault_reg;
  assign LED          = led_reg;
  assign STATE        = state_reg;

endmodule

// File: tb/tb_init_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_init_reset_sequencer
//
// Directed bench for init_reset_sequencer with NUM_CH=4, FILTER=16, STAGGER=8,
// HOLD=32, TIMEOUT=100, BLINK_DIV=4. "cyc" is the index of the most recent
// rising edge since the start of the current scenario (first edge = 0);
// outputs are sampled 1 ns after that edge.
// -----------------------------------------------------------------------------
module tb_init_reset_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       DEVICE_INIT_DONE;
  logic       PLL_LOCK;
  logic       SW_RESET_REQ;
  logic [3:0] RESET_N_OUT;
  logic       ALL_RELEASED;
  logic       FAULT;
  logic       LED;
  logic [2:0] STATE;

  int cyc;
  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 CLK = ~CLK;

  init_reset_sequencer #(
    .NUM_CH(4), .FILTER_CYCLES(16), .STAGGER_CYCLES(8), .HOLD_CYCLES(32),
    .TIMEOUT_CYCLES(100), .BLINK_DIV(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .DEVICE_INIT_DONE(DEVICE_INIT_DONE),
    .PLL_LOCK(PLL_LOCK), .SW_RESET_REQ(SW_RESET_REQ), .RESET_N_OUT(RESET_N_OUT),
    .ALL_RELEASED(ALL_RELEASED), .FAULT(FAULT), .LED(LED), .STATE(STATE)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
    $display("check %-14s cyc %0d observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  // Apply one reset edge, then release RESET with the given qualifiers.
  task automatic do_reset(input logic dev, input logic pll);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET            = 1'b0;
    DEVICE_INIT_DONE = dev;
    PLL_LOCK         = pll;
    cyc              = -1;
  endtask

  initial begin
    RESET = 1'b1; DEVICE_INIT_DONE = 1'b0; PLL_LOCK = 1'b0; SW_RESET_REQ = 1'b0;
    cyc = -1;
    @(posedge CLK); @(posedge CLK); #1;
    chk("rst_state", STATE, 0);
    chk("rst_rstn", RESET_N_OUT, 4'b0000);
    chk("rst_allrel", ALL_RELEASED, 0);
    chk("rst_fault", FAULT, 0);
    chk("rst_led", LED, 0);

    // Clean power-up: filter, then stagger.
    do_reset(1'b1, 1'b1);
    go_to(15); chk("pu_wait", STATE, 0); chk("pu_led_off", LED, 0);
    go_to(16); chk("pu_release", STATE, 1); chk("pu_led_on", LED, 1);
    go_to(23); chk("pu_rstn23", RESET_N_OUT, 4'b0000);
    go_to(24); chk("pu_rstn24", RESET_N_OUT, 4'b0001);
    go_to(32); chk("pu_rstn32", RESET_N_OUT, 4'b0011);
    go_to(40); chk("pu_rstn40", RESET_N_OUT, 4'b0111);
    go_to(47); chk("pu_allrel47", ALL_RELEASED, 0);
    go_to(48); chk("pu_rstn48", RESET_N_OUT, 4'b1111);
    chk("pu_allrel48", ALL_RELEASED, 1); chk("pu_run", STATE, 2);

    // Qualifier glitch in RUN: everything drops, full re-sequence.
    go_to(50); PLL_LOCK = 1'b0;
    go_to(51); PLL_LOCK = 1'b1;
    chk("ql_rstn", RESET_N_OUT, 4'b0000); chk("ql_state", STATE, 0);
    chk("ql_allrel", ALL_RELEASED, 0);
    go_to(67); chk("ql_wait67", STATE, 0);
    go_to(68); chk("ql_release68", STATE, 1);
    go_to(76); chk("ql_rstn76", RESET_N_OUT, 4'b0001);
    go_to(99); chk("ql_rstn99", RESET_N_OUT, 4'b0111);
    go_to(100); chk("ql_rstn100", RESET_N_OUT, 4'b1111); chk("ql_run", STATE, 2);

    // Software reset in RUN: 32-cycle hold, then stagger without filter.
    go_to(102); SW_RESET_REQ = 1'b1;
    go_to(103); SW_RESET_REQ = 1'b0;
    chk("sw_hold", STATE, 3); chk("sw_rstn", RESET_N_OUT, 4'b0000);
    chk("sw_led", LED, 0);
    go_to(134); chk("sw_hold134", STATE, 3);
    go_to(135); chk("sw_release", STATE, 1);
    go_to(140); SW_RESET_REQ = 1'b1;   // ignored outside RUN
    go_to(141); SW_RESET_REQ = 1'b0; chk("sw_ignored", STATE, 1);
    go_to(143); chk("sw_rstn143", RESET_N_OUT, 4'b0001);
    go_to(167); chk("sw_rstn167", RESET_N_OUT, 4'b1111); chk("sw_run", STATE, 2);

    // Filter restart: PLL drops for one cycle at filter count 10.
    do_reset(1'b1, 1'b1);
    go_to(9); PLL_LOCK = 1'b0;
    go_to(10); PLL_LOCK = 1'b1;
    go_to(26); chk("flt_wait26", STATE, 0);
    go_to(27); chk("flt_release27", STATE, 1);

    // RESET mid-RELEASE with two channels out.
    go_to(45); chk("mr_rstn45", RESET_N_OUT, 4'b0011);
    RESET = 1'b1;
    go_to(46);
    chk("mr_rstn", RESET_N_OUT, 4'b0000); chk("mr_state", STATE, 0);
    chk("mr_led", LED, 0);

    // Timeout to FAULT with DEVICE_INIT_DONE held low.
    RESET = 1'b0; DEVICE_INIT_DONE = 1'b0; PLL_LOCK = 1'b1; cyc = -1;
    go_to(99); chk("to_fault99", FAULT, 0); chk("to_state99", STATE, 0);
    go_to(100); chk("to_fault100", FAULT, 1); chk("to_state100", STATE, 4);
    chk("to_led100", LED, 1);
    go_to(103); chk("to_led103", LED, 1);
    go_to(104); chk("to_led104", LED, 0);
    go_to(107); chk("to_led107", LED, 0);
    go_to(108); chk("to_led108", LED, 1);
    DEVICE_INIT_DONE = 1'b1;
    go_to(130); chk("to_sticky", STATE, 4); chk("to_sticky_f", FAULT, 1);
    RESET = 1'b1;
    go_to(131);
    chk("to_clr_state", STATE, 0); chk("to_clr_fault", FAULT, 0);
    chk("to_clr_led", LED, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
